// File: rtl/gsim_residual_check.sv
// Residual checker for the Gauss-Seidel solver: captures b and x, streams r = b*2^16 - A*x per row,
// then reports max |r| and a pass flag against THRESH.
module gsim_residual_check #(
   parameter logic [39:0] THRESH = 40'd4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        b_en_i,
   input  logic [15:0] b_in_i,
   input  logic        x_valid_i,
   input  logic [31:0] x_in_i,
   output logic        res_valid_o,
   output logic [3:0]  res_idx_o,
   output logic [39:0] res_out_o,
   output logic        done_o,
   output logic [39:0] max_abs_o,
   output logic        pass_o,
   output logic        overrun_o
);

   typedef enum logic [2:0] {StIdle, StCapB, StCapX, StCalc, StReport} state_e;

   state_e             state_q, state_d;
   logic [3:0]         b_cnt_q, x_cnt_q, calc_cnt_q, calc_cnt_d;
   logic [15:0]        b_q [16];
   logic [31:0]        x_q [16];
   logic               b_we, x_we;
   logic               res_valid_q, res_valid_d, done_q, done_d, pass_q, pass_d;
   logic               overrun_q, overrun_d;
   logic [3:0]         res_idx_q, res_idx_d;
   logic [39:0]        res_out_q, res_out_d, max_abs_q, max_abs_d, run_max_q, run_max_d;
   logic [39:0]        abs_q;
   logic [3:0]         rsel;
   logic [4:0]         base;
   logic signed [39:0] xe [22];
   logic signed [39:0] c0, s1, s2, s3, bterm, resid;

   // Row being computed is the one that becomes visible after the next edge.
   assign rsel = (state_q == StCalc) ? calc_cnt_q + 4'd1 : 4'd0;
   assign base = {1'b0, rsel} + 5'd3;

   // x padded with three zero entries on each side so edge rows need no special case.
   always_comb begin
      for (int k = 0; k < 22; k++) xe[k] = '0;
      for (int k = 0; k < 16; k++) xe[k+3] = {{8{x_q[k][31]}}, x_q[k]};
   end

   always_comb begin
      c0    = xe[base];
      s1    = xe[base - 5'd1] + xe[base + 5'd1];
      s2    = xe[base - 5'd2] + xe[base + 5'd2];
      s3    = xe[base - 5'd3] + xe[base + 5'd3];
      bterm = {{8{b_q[rsel][15]}}, b_q[rsel], 16'h0000};
      resid = bterm - ((c0 <<< 4) + (c0 <<< 2)) + ((s1 <<< 3) + (s1 <<< 2) + s1)
              - ((s2 <<< 2) + (s2 <<< 1)) + s3;
   end

   assign abs_q = res_out_q[39] ? (~res_out_q + 40'd1) : res_out_q;

   always_comb begin
      state_d     = state_q;
      b_we        = 1'b0;
      x_we        = 1'b0;
      calc_cnt_d  = calc_cnt_q;
      overrun_d   = overrun_q;
      res_valid_d = 1'b0;
      res_idx_d   = '0;
      res_out_d   = '0;
      done_d      = 1'b0;
      max_abs_d   = max_abs_q;
      pass_d      = pass_q;
      run_max_d   = run_max_q;
      unique case (state_q)
         StIdle: begin
            if (x_valid_i) overrun_d = 1'b1;
            if (b_en_i) begin
               b_we    = 1'b1;
               state_d = StCapB;
            end
         end
         StCapB: begin
            if (x_valid_i) overrun_d = 1'b1;
            if (b_en_i) begin
               b_we = 1'b1;
               if (b_cnt_q == 4'd15) state_d = StCapX;
            end
         end
         StCapX: begin
            if (b_en_i) overrun_d = 1'b1;
            if (x_valid_i) begin
               x_we = 1'b1;
               if (x_cnt_q == 4'd15) begin
                  state_d     = StCalc;
                  calc_cnt_d  = '0;
                  run_max_d   = '0;
                  res_valid_d = 1'b1;
                  res_idx_d   = rsel;
                  res_out_d   = resid;
               end
            end
         end
         StCalc: begin
            if (b_en_i || x_valid_i) overrun_d = 1'b1;
            run_max_d = (abs_q > run_max_q) ? abs_q : run_max_q;
            if (calc_cnt_q == 4'd15) begin
               state_d    = StReport;
               calc_cnt_d = '0;
               done_d     = 1'b1;
               max_abs_d  = run_max_d;
               pass_d     = (run_max_d <= THRESH);
            end else begin
               calc_cnt_d  = calc_cnt_q + 4'd1;
               res_valid_d = 1'b1;
               res_idx_d   = rsel;
               res_out_d   = resid;
            end
         end
         StReport: begin
            if (b_en_i || x_valid_i) overrun_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         b_cnt_q     <= '0;
         x_cnt_q     <= '0;
         calc_cnt_q  <= '0;
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_out_q   <= '0;
         done_q      <= 1'b0;
         max_abs_q   <= '0;
         pass_q      <= 1'b0;
         overrun_q   <= 1'b0;
         run_max_q   <= '0;
         for (int k = 0; k < 16; k++) begin
            b_q[k] <= '0;
            x_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         calc_cnt_q  <= calc_cnt_d;
         res_valid_q <= res_valid_d;
         res_idx_q   <= res_idx_d;
         res_out_q   <= res_out_d;
         done_q      <= done_d;
         max_abs_q   <= max_abs_d;
         pass_q      <= pass_d;
         overrun_q   <= overrun_d;
         run_max_q   <= run_max_d;
         if (b_we) begin
            b_q[b_cnt_q] <= b_in_i;
            b_cnt_q      <= b_cnt_q + 4'd1;
         end
         if (x_we) begin
            x_q[x_cnt_q] <= x_in_i;
            x_cnt_q      <= x_cnt_q + 4'd1;
         end
      end
   end

   assign res_valid_o = res_valid_q;
   assign res_idx_o   = res_idx_q;
   assign res_out_o   = res_out_q;
   assign done_o      = done_q;
   assign max_abs_o   = max_abs_q;
   assign pass_o      = pass_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_gsim_residual_check.sv
// Directed bench for gsim_residual_check: table of uniform b/x frames plus protocol and reset cases.
module tb_gsim_residual_check;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        b_en = 1'b0;
   logic [15:0] b_in = '0;
   logic        x_valid = 1'b0;
   logic [31:0] x_in = '0;
   logic        res_valid;
   logic [3:0]  res_idx;
   logic [39:0] res_out;
   logic        done;
   logic [39:0] max_abs;
   logic        pass;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   gsim_residual_check #(.THRESH(40'd4096)) dut (
      .clk        (clk),
      .reset      (reset),
      .b_en_i     (b_en),
      .b_in_i     (b_in),
      .x_valid_i  (x_valid),
      .x_in_i     (x_in),
      .res_valid_o(res_valid),
      .res_idx_o  (res_idx),
      .res_out_o  (res_out),
      .done_o     (done),
      .max_abs_o  (max_abs),
      .pass_o     (pass),
      .overrun_o  (overrun)
   );

   always #5 clk = ~clk;

   // Uniform b and x per frame; expected residuals by row group (edge, +-1, +-2, interior).
   typedef struct {
      logic [15:0] b;
      logic [31:0] x;
      bit          gap;
      longint      r0;
      longint      r1;
      longint      r2;
      longint      rm;
      longint      mx;
      longint      ps;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint exp_row(input vec_t v, input int row);
      if (row == 0 || row == 15) return v.r0;
      if (row == 1 || row == 14) return v.r1;
      if (row == 2 || row == 13) return v.r2;
      return v.rm;
   endfunction

   task automatic send_b(input logic [15:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         b_en = 1'b1;
         b_in = b;
      end
      @(posedge clk); #1;
      b_en = 1'b0;
   endtask

   task automatic send_x(input logic [31:0] x, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         x_valid = 1'b1;
         x_in    = x;
         if (gap && i < n - 1) begin
            @(posedge clk); #1;
            x_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      x_valid = 1'b0;
   endtask

   // Starts right after the edge that captured the 16th x beat.
   task automatic check_frame(input vec_t v, input string tag);
      for (int row = 0; row < 16; row++) begin
         @(negedge clk);
         chk({tag, " res_valid"}, longint'(res_valid), 1);
         chk({tag, " res_idx"}, longint'(res_idx), row);
         chk({tag, " res_out"}, longint'($signed(res_out)), exp_row(v, row));
      end
      @(negedge clk);
      chk({tag, " res_valid_end"}, longint'(res_valid), 0);
      chk({tag, " done"}, longint'(done), 1);
      chk({tag, " max_abs"}, longint'(max_abs), v.mx);
      chk({tag, " pass"}, longint'(pass), v.ps);
   endtask

   initial begin
      vecs[0] = '{16'd0,     32'd0,          1'b0, 0, 0, 0, 0, 0, 1};
      vecs[1] = '{16'd1,     32'd0,          1'b0, 65536, 65536, 65536, 65536, 65536, 0};
      vecs[2] = '{16'd0,     32'h0001_0000,  1'b0, -786432, 65536, -327680, -262144, 786432, 0};
      vecs[3] = '{16'd0,     32'h0001_0000,  1'b1, -786432, 65536, -327680, -262144, 786432, 0};
      vecs[4] = '{16'hFFFF,  32'd0,          1'b0, -65536, -65536, -65536, -65536, 65536, 0};
      vecs[5] = '{16'd0,     32'd341,        1'b0, -4092, 341, -1705, -1364, 4092, 1};
      vecs[6] = '{16'd0,     32'd342,        1'b0, -4104, 342, -1710, -1368, 4104, 0};
      vecs[7] = '{16'd0,     32'hFFFF_0000,  1'b0, 786432, -65536, 327680, 262144, 786432, 0};
      vecs[8] = '{16'd2,     32'h0001_0000,  1'b0, -655360, 196608, -196608, -131072, 655360, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst res_valid", longint'(res_valid), 0);
      chk("rst res_out", longint'(res_out), 0);
      chk("rst done", longint'(done), 0);
      chk("rst max_abs", longint'(max_abs), 0);
      chk("rst pass", longint'(pass), 0);
      chk("rst overrun", longint'(overrun), 0);
      reset = 1'b0;

      for (int v = 0; v < 9; v++) begin
         send_b(vecs[v].b, 16);
         send_x(vecs[v].x, 16, vecs[v].gap);
         check_frame(vecs[v], $sformatf("vec%0d", v));
         chk($sformatf("vec%0d overrun", v), longint'(overrun), 0);
      end

      // Stray x beat while b is still being captured.
      send_b(16'd0, 5);
      @(posedge clk); #1;
      x_valid = 1'b1;
      x_in    = 32'h7FFF_0000;
      @(posedge clk); #1;
      x_valid = 1'b0;
      @(negedge clk);
      chk("proto overrun", longint'(overrun), 1);
      send_b(16'd0, 11);
      send_x(32'd0, 16, 1'b0);
      check_frame(vecs[0], "proto");
      chk("proto overrun_sticky", longint'(overrun), 1);

      // Asynchronous reset in the middle of the residual stream.
      send_b(16'd0, 16);
      send_x(32'h0001_0000, 16, 1'b0);
      for (int row = 0; row < 8; row++) @(negedge clk);
      chk("mid res_idx", longint'(res_idx), 7);
      chk("mid res_out", longint'($signed(res_out)), exp_row(vecs[2], 7));
      reset = 1'b1;
      #1;
      chk("mid rst res_valid", longint'(res_valid), 0);
      chk("mid rst done", longint'(done), 0);
      chk("mid rst max_abs", longint'(max_abs), 0);
      chk("mid rst pass", longint'(pass), 0);
      chk("mid rst overrun", longint'(overrun), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      send_b(16'd0, 16);
      send_x(32'd0, 16, 1'b0);
      check_frame(vecs[0], "post_rst");
      chk("post_rst overrun", longint'(overrun), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gsim_residual_check.md
Name: gsim_residual_check

Overview:
- Verification-assist stage directly downstream of the Gauss-Seidel solver.
- Snoops the same 16-entry b stream that feeds the solver and captures the solver's 16-entry x output burst.
- Computes the residual r = b·2^16 − A·x for each row of the fixed 16×16 banded matrix (diagonal 20, ±1 → −13, ±2 → +6, ±3 → −1), one row per cycle.
- Streams out the residuals, then reports the maximum |r| and a pass/fail flag against a threshold.

Parameters:
THRESH, 40'd4096, pass limit on max |r| (16.16 LSBs; 4096 = 1/16)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
b_en  input  1  b sample valid (same strobe as solver in_en)
b_in  input  16  b sample, signed integer, row order 0..15
x_valid  input  1  solver out_valid
x_in  input  32  solver x_out, signed 16.16, row order 0..15
res_valid  output  1  residual output valid
res_idx  output  4  row index of res_out
res_out  output  40  signed residual, 16.16
done  output  1  one-cycle pulse: max_abs and pass are valid
max_abs  output  40  max |r| over the frame (unsigned); held until next frame
pass  output  1  max_abs <= THRESH; held with max_abs
overrun  output  1  sticky protocol-error flag

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, b/x storage cleared.
- FSM states and transitions:
  - IDLE: b_en → CAP_B. The first sample is captured in the same cycle; b_cnt becomes 1.
  - CAP_B: each b_en cycle stores b_in at b[b_cnt] and increments b_cnt. Gaps (b_en low) are allowed. When the 16th sample is stored, go to CAP_X.
  - CAP_X: each x_valid cycle stores x_in at x[x_cnt]. Gaps are allowed. When the 16th sample is stored, go to CALC. Any b_en seen in CAP_X is ignored and sets overrun.
  - CALC: 16 cycles, row i = calc_cnt. res_valid=1, res_idx=i, res_out=r_i, all registered outputs.
    - First res_valid is the cycle after the 16th x is captured.
    - max_abs accumulates as a running max, starting from 0 at CALC entry.
  - REPORT: one cycle. done=1; max_abs and pass update on this cycle's edge; then return to IDLE.
- Protocol errors:
  - x_valid in IDLE or CAP_B: ignored, sets overrun.
  - b_en or x_valid in CALC or REPORT: ignored, sets overrun.
  - overrun clears only on reset.
- Arithmetic: r_i = sext(b_i)<<16 − 20·x_i + 13·(x_{i−1}+x_{i+1}) − 6·(x_{i−2}+x_{i+2}) + (x_{i−3}+x_{i+3}).
  - Out-of-range indices (<0 or >15) contribute 0.
  - Compute at 40-bit signed with x sign-extended; no saturation is needed (max magnitude < 2^38).
  - Multiplies by constants are implemented as shift-add.
- |r|: two's-complement negate when negative, taken at 40 bits. Comparison is unsigned.
- max_abs/pass hold their last frame values until the next REPORT. pass is 0 after reset until the first REPORT.
- Reset mid-operation (any state): immediate return to IDLE, outputs zeroed, partial frame discarded.
- Back-to-back frames: b_en in the cycle after REPORT is accepted (IDLE → CAP_B).

Test Plan:
- Zero frame: b=0 ×16, x=0 ×16 → 16 res_valid cycles with res_out=0 and res_idx 0..15; done with max_abs=0, pass=1, overrun=0.
- Unit b, zero x: b=1 ×16, x=0 ×16 → every res_out=65536; max_abs=65536, pass=0.
- Uniform x=0x00010000, b=0 → expected residuals:
  - r0 = r15 = −786432
  - r1 = r14 = +65536
  - r2 = r13 = −327680
  - r3..r12 = −262144
  - max_abs = 786432, pass = 0
- Gapped x stream: x_valid toggling every other cycle with the same data as the previous scenario → identical residuals. First res_valid exactly one cycle after the 16th x beat.
- Protocol error: x_valid pulse during CAP_B → overrun=1 and the x sample is not stored. Frame still completes correctly once the 16 legitimate x beats arrive.
- Reset during CALC at row 7: assert reset → res_valid, done, max_abs, pass, overrun all 0 immediately. A following clean zero frame produces pass=1.
